// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU functions,
// datapath select encodings, FSM states and the control-word structure.
package mc_control_unit_pkg;

  // RV32 base opcodes (IR[6:0])
  localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_ECALL   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_func_e;

  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;
  localparam logic [1:0] WB_ALUOUT    = 2'd0;
  localparam logic [1:0] WB_MDR       = 2'd1;
  localparam logic [1:0] WB_ALU       = 2'd2;
  localparam logic       PCSRC_ALU    = 1'b0;
  localparam logic       PCSRC_ALUOUT = 1'b1;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_PC4  = 3'd5,
    ST_JWB  = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_ECALL  = 4'd7,
    CLS_OTHER  = 4'd8
  } op_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op_sel;
    logic [1:0] wb_sel;
    logic       pc_source;
    logic       halted;
  } ctrl_t;

  function automatic op_class_e classify_op(input logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_R_TYPE:  cls = CLS_R;
      OP_I_ARITH: cls = CLS_I;
      OP_LOAD:    cls = CLS_LOAD;
      OP_STORE:   cls = CLS_STORE;
      OP_BRANCH:  cls = CLS_BRANCH;
      OP_JAL:     cls = CLS_JAL;
      OP_JALR:    cls = CLS_JALR;
      OP_ECALL:   cls = CLS_ECALL;
      default:    cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

  // Control word that advances PC by 4 through the ALU result path
  function automatic ctrl_t pc_plus4_ctrl();
    ctrl_t c;
    c            = '0;
    c.pc_write   = 1'b1;
    c.pc_source  = PCSRC_ALU;
    c.alu_src_a  = SRCA_PC;
    c.alu_src_b  = SRCB_FOUR;
    c.alu_op_sel = ALUOP_ADD;
    return c;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control/status bundle between the control unit (master) and the datapath (slave).
interface mc_control_unit_if;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       mem_ready;
  logic       is_halt;

  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mdr_write;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op_sel;
  logic [1:0] wb_sel;
  logic       pc_source;
  logic       halted;

  modport master (
    input  opcode, alu_bcond, mem_ready, is_halt,
    output pc_write, iord, mem_read, mem_write, ir_write, mdr_write, reg_write,
           alu_src_a, alu_src_b, alu_op_sel, wb_sel, pc_source, halted
  );

  modport slave (
    output opcode, alu_bcond, mem_ready, is_halt,
    input  pc_write, iord, mem_read, mem_write, ir_write, mdr_write, reg_write,
           alu_src_a, alu_src_b, alu_op_sel, wb_sel, pc_source, halted
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32 control FSM: IF/ID/EX/MEM/WB plus PC4, JWB and HALT states.
// Outputs are decoded from state (Mealy on mem_ready/alu_bcond) and forced low during reset.
module mc_control_unit
  import mc_control_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_control_unit_if.master bus
);

  state_e    state_r;
  state_e    next_state_s;
  op_class_e op_r;
  op_class_e id_class_s;
  ctrl_t     ctrl_s;
  ctrl_t     out_s;

  assign id_class_s = classify_op(bus.opcode);

  // State register; reset returns to IF from any state, including MEM and HALT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction class captured leaving ID so later states ignore IR changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r <= CLS_OTHER;
    end else if (state_r == ST_ID) begin
      op_r <= id_class_s;
    end else begin
      op_r <= op_r;
    end
  end

  // Next-state and control-word decode
  always_comb begin
    next_state_s = state_r;
    ctrl_s       = '0;
    case (state_r)
      ST_IF: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.iord     = IORD_PC;
        if (bus.mem_ready) begin
          ctrl_s.ir_write = 1'b1;
          next_state_s    = ST_ID;
        end else begin
          next_state_s = ST_IF;
        end
      end

      ST_ID: begin
        ctrl_s.alu_src_a  = SRCA_PC;
        ctrl_s.alu_src_b  = SRCB_IMM;
        ctrl_s.alu_op_sel = ALUOP_ADD;
        case (id_class_s)
          CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR: next_state_s = ST_EX;
          CLS_JAL: next_state_s = ST_JWB;
          CLS_ECALL: begin
            if (bus.is_halt) begin
              next_state_s = ST_HALT;
            end else begin
              next_state_s = ST_PC4;
            end
          end
          default: next_state_s = ST_PC4;
        endcase
      end

      ST_EX: begin
        ctrl_s.alu_src_a = SRCA_A;
        case (op_r)
          CLS_R: begin
            ctrl_s.alu_src_b  = SRCB_B;
            ctrl_s.alu_op_sel = ALUOP_FUNCT;
            next_state_s      = ST_WB;
          end
          CLS_I: begin
            ctrl_s.alu_src_b  = SRCB_IMM;
            ctrl_s.alu_op_sel = ALUOP_FUNCT;
            next_state_s      = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            ctrl_s.alu_src_b  = SRCB_IMM;
            ctrl_s.alu_op_sel = ALUOP_ADD;
            next_state_s      = ST_MEM;
          end
          CLS_BRANCH: begin
            ctrl_s.alu_src_b  = SRCB_B;
            ctrl_s.alu_op_sel = ALUOP_SUB;
            // Taken branch loads the ID-computed target from ALUOut right away
            if (bus.alu_bcond) begin
              ctrl_s.pc_write  = 1'b1;
              ctrl_s.pc_source = PCSRC_ALUOUT;
              next_state_s     = ST_IF;
            end else begin
              next_state_s = ST_PC4;
            end
          end
          CLS_JALR: begin
            ctrl_s.alu_src_b  = SRCB_IMM;
            ctrl_s.alu_op_sel = ALUOP_ADD;
            next_state_s      = ST_JWB;
          end
          default: begin
            ctrl_s       = '0;
            next_state_s = ST_PC4;
          end
        endcase
      end

      ST_MEM: begin
        case (op_r)
          CLS_LOAD: begin
            ctrl_s.iord     = IORD_ALUOUT;
            ctrl_s.mem_read = 1'b1;
            if (bus.mem_ready) begin
              ctrl_s.mdr_write = 1'b1;
              next_state_s     = ST_WB;
            end else begin
              next_state_s = ST_MEM;
            end
          end
          CLS_STORE: begin
            if (bus.mem_ready) begin
              ctrl_s       = pc_plus4_ctrl();
              next_state_s = ST_IF;
            end else begin
              next_state_s = ST_MEM;
            end
            ctrl_s.iord      = IORD_ALUOUT;
            ctrl_s.mem_write = 1'b1;
          end
          default: next_state_s = ST_IF;
        endcase
      end

      ST_WB: begin
        ctrl_s           = pc_plus4_ctrl();
        ctrl_s.reg_write = 1'b1;
        if (op_r == CLS_LOAD) begin
          ctrl_s.wb_sel = WB_MDR;
        end else begin
          ctrl_s.wb_sel = WB_ALUOUT;
        end
        next_state_s = ST_IF;
      end

      ST_PC4: begin
        ctrl_s       = pc_plus4_ctrl();
        next_state_s = ST_IF;
      end

      ST_JWB: begin
        // rd <= PC+4 from the live ALU result while PC takes the jump target in ALUOut
        ctrl_s           = pc_plus4_ctrl();
        ctrl_s.reg_write = 1'b1;
        ctrl_s.wb_sel    = WB_ALU;
        ctrl_s.pc_source = PCSRC_ALUOUT;
        next_state_s     = ST_IF;
      end

      ST_HALT: begin
        ctrl_s.halted = 1'b1;
        next_state_s  = ST_HALT;
      end

      default: begin
        ctrl_s       = '0;
        next_state_s = ST_IF;
      end
    endcase
  end

  // Reset masks every control output immediately
  always_comb begin
    if (reset) begin
      out_s = '0;
    end else begin
      out_s = ctrl_s;
    end
  end

  assign bus.pc_write   = out_s.pc_write;
  assign bus.iord       = out_s.iord;
  assign bus.mem_read   = out_s.mem_read;
  assign bus.mem_write  = out_s.mem_write;
  assign bus.ir_write   = out_s.ir_write;
  assign bus.mdr_write  = out_s.mdr_write;
  assign bus.reg_write  = out_s.reg_write;
  assign bus.alu_src_a  = out_s.alu_src_a;
  assign bus.alu_src_b  = out_s.alu_src_b;
  assign bus.alu_op_sel = out_s.alu_op_sel;
  assign bus.wb_sel     = out_s.wb_sel;
  assign bus.pc_source  = out_s.pc_source;
  assign bus.halted     = out_s.halted;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized instruction-level bench for mc_control_unit: each instruction is expanded
// into its expected cycle sequence and every cycle is compared against the DUT.
`timescale 1ns/1ps
module tb_mc_control_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mc_control_unit_if bus();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] name;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        bcond;
    logic        is_halt;
    logic [15:0] exp;
  } step_t;

  step_t       q[$];
  int          n_checks   = 0;
  int          n_fail     = 0;
  logic        cur_valid  = 1'b0;
  logic [15:0] cur_exp    = 16'h0000;
  logic [63:0] cur_name   = "RESET";
  logic        need_reset = 1'b0;
  logic [15:0] dut_v;

  assign dut_v = {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                  bus.mdr_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op_sel, bus.wb_sel, bus.pc_source, bus.halted};

  function automatic logic [15:0] vec(input logic pcw, input logic iord, input logic mr,
                                      input logic mw, input logic irw, input logic mdrw,
                                      input logic rw, input logic sa, input logic [1:0] sb,
                                      input logic [1:0] op, input logic [1:0] wb,
                                      input logic ps, input logic h);
    return {pcw, iord, mr, mw, irw, mdrw, rw, sa, sb, op, wb, ps, h};
  endfunction

  // Expected control words, one per behaviour described for each state
  function automatic logic [15:0] e_if(input logic rdy);
    return vec(1'b0,1'b0,1'b1,1'b0,rdy,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0);
  endfunction
  function automatic logic [15:0] e_id();
    return vec(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd0,1'b0,1'b0);
  endfunction
  function automatic logic [15:0] e_ex(input logic [1:0] sb, input logic [1:0] op, input logic taken);
    return vec(taken,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,sb,op,2'd0,taken,1'b0);
  endfunction
  function automatic logic [15:0] e_mem_ld(input logic rdy);
    return vec(1'b0,1'b1,1'b1,1'b0,1'b0,rdy,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0);
  endfunction
  function automatic logic [15:0] e_mem_st(input logic rdy);
    return vec(rdy,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,{1'b0,rdy},2'd0,2'd0,1'b0,1'b0);
  endfunction
  function automatic logic [15:0] e_wb(input logic ld);
    return vec(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd1,2'd0,{1'b0,ld},1'b0,1'b0);
  endfunction
  function automatic logic [15:0] e_pc4();
    return vec(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0,1'b0);
  endfunction
  function automatic logic [15:0] e_jwb();
    return vec(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd1,2'd0,2'd2,1'b1,1'b0);
  endfunction
  function automatic logic [15:0] e_halt();
    return vec(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,1'b1);
  endfunction

  function automatic logic rb();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  function automatic logic [6:0] rnd7();
    logic [31:0] r;
    r = $urandom;
    return r[6:0];
  endfunction

  // 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 ECALL, 8 unrecognised
  function automatic logic [6:0] opcode_of(input int cls);
    logic [6:0] others [5];
    others[0] = 7'b0000000; others[1] = 7'b0001111; others[2] = 7'b0110111;
    others[3] = 7'b0010111; others[4] = 7'b1111111;
    case (cls)
      0: return 7'b0110011;
      1: return 7'b0010011;
      2: return 7'b0000011;
      3: return 7'b0100011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      6: return 7'b1100111;
      7: return 7'b1110011;
      default: return others[$urandom_range(0, 4)];
    endcase
  endfunction

  task automatic push(input logic [63:0] nm, input logic [6:0] opc, input logic mr,
                      input logic b, input logic h, input logic [15:0] e);
    step_t s;
    s.name = nm; s.opcode = opc; s.mem_ready = mr; s.bcond = b; s.is_halt = h; s.exp = e;
    q.push_back(s);
  endtask

  // Expand one instruction into its expected cycles; mode<0 means randomize
  task automatic build_instr(input int cls, input int halt_mode, input int mem_waits);
    logic halt_req;
    logic taken;
    int   w;
    halt_req = (halt_mode < 0) ? rb() : (halt_mode != 0);
    taken    = rb();
    w        = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) push("IF_WAIT", rnd7(), 1'b0, rb(), rb(), e_if(1'b0));
    push("IF", rnd7(), 1'b1, rb(), rb(), e_if(1'b1));
    push("ID", opcode_of(cls), rb(), rb(), (cls == 7) ? halt_req : rb(), e_id());
    w = (mem_waits < 0) ? $urandom_range(0, 3) : mem_waits;
    case (cls)
      0: begin
        push("EX_R", rnd7(), rb(), rb(), rb(), e_ex(2'd0, 2'd2, 1'b0));
        push("WB", rnd7(), rb(), rb(), rb(), e_wb(1'b0));
      end
      1: begin
        push("EX_I", rnd7(), rb(), rb(), rb(), e_ex(2'd2, 2'd2, 1'b0));
        push("WB", rnd7(), rb(), rb(), rb(), e_wb(1'b0));
      end
      2: begin
        push("EX_LD", rnd7(), rb(), rb(), rb(), e_ex(2'd2, 2'd0, 1'b0));
        for (int i = 0; i < w; i++) push("MEM_LDW", rnd7(), 1'b0, rb(), rb(), e_mem_ld(1'b0));
        push("MEM_LD", rnd7(), 1'b1, rb(), rb(), e_mem_ld(1'b1));
        push("WB_LD", rnd7(), rb(), rb(), rb(), e_wb(1'b1));
      end
      3: begin
        push("EX_ST", rnd7(), rb(), rb(), rb(), e_ex(2'd2, 2'd0, 1'b0));
        for (int i = 0; i < w; i++) push("MEM_STW", rnd7(), 1'b0, rb(), rb(), e_mem_st(1'b0));
        push("MEM_ST", rnd7(), 1'b1, rb(), rb(), e_mem_st(1'b1));
      end
      4: begin
        push("EX_BR", rnd7(), rb(), taken, rb(), e_ex(2'd0, 2'd1, taken));
        if (!taken) push("PC4", rnd7(), rb(), rb(), rb(), e_pc4());
      end
      5: push("JWB", rnd7(), rb(), rb(), rb(), e_jwb());
      6: begin
        push("EX_JALR", rnd7(), rb(), rb(), rb(), e_ex(2'd2, 2'd0, 1'b0));
        push("JWB", rnd7(), rb(), rb(), rb(), e_jwb());
      end
      7: begin
        if (halt_req) begin
          for (int i = 0; i < 20; i++) push("HALT", rnd7(), rb(), rb(), rb(), e_halt());
          need_reset = 1'b1;
        end else begin
          push("PC4", rnd7(), rb(), rb(), rb(), e_pc4());
        end
      end
      default: push("PC4", rnd7(), rb(), rb(), rb(), e_pc4());
    endcase
  endtask

  task automatic play();
    step_t s;
    while (q.size() > 0) begin
      s             = q.pop_front();
      bus.opcode    = s.opcode;
      bus.mem_ready = s.mem_ready;
      bus.alu_bcond = s.bcond;
      bus.is_halt   = s.is_halt;
      cur_name      = s.name;
      cur_exp       = s.exp;
      cur_valid     = 1'b1;
      @(posedge clk);
      #1;
    end
    cur_valid = 1'b0;
  endtask

  // Single compare point, mid-cycle on the falling edge
  always @(negedge clk) begin
    if (cur_valid) begin
      n_checks++;
      if (dut_v !== cur_exp) begin
        n_fail++;
        $display("FAIL %s at %0t: got %h, expected %h", cur_name, $time, dut_v, cur_exp);
      end
    end
  end

  task automatic chk(input logic [63:0] nm, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
    end
  endtask

  // Hold reset two cycles with random inputs, release just before a rising edge
  task automatic apply_reset();
    reset         = 1'b1;
    bus.opcode    = rnd7();
    bus.mem_ready = rb();
    bus.alu_bcond = rb();
    bus.is_halt   = rb();
    cur_name      = "RESET";
    cur_exp       = 16'h0000;
    cur_valid     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    cur_valid     = 1'b0;
    bus.mem_ready = 1'b0;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Cycles from the first IF cycle to the next fetch (or to halted) with mem_ready high
  task automatic check_latency(input logic [63:0] nm, input logic [6:0] opc,
                               input logic b, input logic h, input int want);
    int idx;
    idx = -1;
    apply_reset();
    bus.opcode = opc; bus.mem_ready = 1'b1; bus.alu_bcond = b; bus.is_halt = h;
    for (int i = 0; i < 20 && idx < 0; i++) begin
      @(negedge clk);
      if (i > 0 && (bus.ir_write || bus.halted)) idx = i;
    end
    n_checks++;
    if (idx != want) begin
      n_fail++;
      $display("FAIL latency %s: got %0d cycles, expected %0d", nm, idx, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.opcode = 7'd0; bus.mem_ready = 1'b0; bus.alu_bcond = 1'b0; bus.is_halt = 1'b0;
    apply_reset();

    check_latency("R",      7'b0110011, 1'b0, 1'b0, 4);
    check_latency("I",      7'b0010011, 1'b0, 1'b0, 4);
    check_latency("LOAD",   7'b0000011, 1'b0, 1'b0, 5);
    check_latency("STORE",  7'b0100011, 1'b0, 1'b0, 4);
    check_latency("BR_T",   7'b1100011, 1'b1, 1'b0, 3);
    check_latency("BR_NT",  7'b1100011, 1'b0, 1'b0, 4);
    check_latency("JAL",    7'b1101111, 1'b0, 1'b0, 3);
    check_latency("JALR",   7'b1100111, 1'b0, 1'b0, 4);
    check_latency("HALT",   7'b1110011, 1'b0, 1'b1, 2);

    // Reset asserted mid-MEM of a stalled store
    apply_reset();
    push("IF", rnd7(), 1'b1, 1'b0, 1'b0, e_if(1'b1));
    push("ID", 7'b0100011, 1'b0, 1'b0, 1'b0, e_id());
    push("EX_ST", rnd7(), 1'b0, 1'b0, 1'b0, e_ex(2'd2, 2'd0, 1'b0));
    play();
    bus.mem_ready = 1'b0;
    bus.opcode    = rnd7();
    #2;
    chk("MEM_ST_HOLD", dut_v, e_mem_st(1'b0));
    #1;
    reset = 1'b1;
    #1;
    chk("RST_MID_MEM", dut_v, 16'h0000);
    apply_reset();
    #2;
    chk("IF_AFTER_RST", dut_v, e_if(1'b0));
    @(posedge clk);
    #1;

    // Directed corners, then random instruction stream
    apply_reset();
    build_instr(2, 0, 3);  play();
    build_instr(0, 0, 0);  play();
    build_instr(7, 0, 0);  play();
    build_instr(8, 0, 0);  play();
    build_instr(7, 1, 0);  play();
    apply_reset();
    need_reset = 1'b0;
    for (int n = 0; n < 300; n++) begin
      build_instr($urandom_range(0, 8), -1, -1);
      play();
      if (need_reset) begin
        apply_reset();
        need_reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
